gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_sync.sv | 27 ++
 rtl/gpio_port.sv | 85 ++++++++
 tb/tb_gpio_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: default pin count and direction encodings.
package gpio_pkg;

  localparam int GPIO_WIDTH = 8;

  typedef enum logic {
    DIR_OUT = 1'b0,
    DIR_IN  = 1'b1
  } gpio_dir_e;

endpackage

// File: rtl/gpio_sync.sv
// Two-stage per-bit synchronizer for pad inputs that are asynchronous to clk.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  // NOTE: flops use non-blocking assignments so both stages sample pre-edge
  // values; blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/gpio_port.sv
// N-pin GPIO port: output data register, registered readback, optional
// edge-triggered interrupt logic built only when GPIO_IRQ_EN is defined.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int N = GPIO_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] gpio_in,
  input  logic [N-1:0] gpio_direction,
  output logic [N-1:0] gpio_out,
  output logic [N-1:0] gpio_oe,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  output logic [N-1:0] rd_data,
  input  logic [N-1:0] irq_en,
  input  logic [N-1:0] irq_clr,
  output logic [N-1:0] irq_status,
  output logic         irq
);

  logic [N-1:0] sync_in;
  logic [N-1:0] out_reg;
  logic [N-1:0] pin_is_in;

  gpio_sync #(.WIDTH(N)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_in),
    .q     (sync_in)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pin_is_in = '0;
    for (int i = 0; i < N; i++) begin
      pin_is_in[i] = (gpio_direction[i] == DIR_IN);
    end
  end

  assign gpio_out = out_reg & ~pin_is_in;
  assign gpio_oe  = ~pin_is_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        out_reg <= wr_data;
      end
      rd_data <= (sync_in & pin_is_in) | (out_reg & ~pin_is_in);
    end
  end

`ifdef GPIO_IRQ_EN
  logic [N-1:0] prev_in;
  logic [N-1:0] edge_hit;

  // prev_in resets to the same value as the synchronizer, so releasing reset
  // cannot look like an edge.
  assign edge_hit = (sync_in ^ prev_in) & pin_is_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_in    <= '0;
      irq_status <= '0;
    end else begin
      prev_in    <= sync_in;
      irq_status <= (irq_status & ~irq_clr) | edge_hit;
    end
  end

  assign irq = |(irq_status & irq_en);
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{irq_en, irq_clr};
  assign irq_status        = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: expectations are queued with a due cycle
// when stimulus is applied and compared on the falling edge of that cycle.
module tb_gpio_port;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] gpio_in;
  logic [N-1:0] gpio_direction;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_oe;
  logic         wr_en;
  logic [N-1:0] wr_data;
  logic [N-1:0] rd_data;
  logic [N-1:0] irq_en;
  logic [N-1:0] irq_clr;
  logic [N-1:0] irq_status;
  logic         irq;

  always #5 clk = ~clk;

  gpio_port #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .gpio_in        (gpio_in),
    .gpio_direction (gpio_direction),
    .gpio_out       (gpio_out),
    .gpio_oe        (gpio_oe),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .irq_en         (irq_en),
    .irq_clr        (irq_clr),
    .irq_status     (irq_status),
    .irq            (irq)
  );

  typedef enum {SIG_OUT, SIG_OE, SIG_RD, SIG_ST, SIG_IRQ} sig_e;

  typedef struct {
    int         due;
    sig_e       sig;
    logic [7:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Queue an expectation for the falling edge dly rising edges from now.
  task automatic expect_at(input int dly, input sig_e s, input logic [7:0] v, input string tag);
    sb.push_back('{cyc + dly, s, v, tag});
  endtask

  function automatic logic [7:0] irqv(input logic [7:0] v);
`ifdef GPIO_IRQ_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sig)
          SIG_OUT: act = gpio_out;
          SIG_OE:  act = gpio_oe;
          SIG_RD:  act = rd_data;
          SIG_ST:  act = irq_status;
          default: act = {7'b0, irq};
        endcase
        check(sb[i].tag, act, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    // Reset held with busy inputs: everything must read zero.
    reset          = 1'b0;
    gpio_in        = 8'hFF;
    gpio_direction = 8'h00;
    wr_en          = 1'b1;
    wr_data        = 8'h77;
    irq_en         = 8'hFF;
    irq_clr        = 8'h00;
    tick(2);
    expect_at(0, SIG_OUT, 8'h00, "rst_out");
    expect_at(0, SIG_RD,  8'h00, "rst_rd");
    expect_at(0, SIG_ST,  8'h00, "rst_status");
    expect_at(0, SIG_IRQ, 8'h00, "rst_irq");

    // Release with inputs quiet: no edge flags may appear.
    gpio_in        = 8'h00;
    gpio_direction = 8'hFF;
    wr_en          = 1'b0;
    irq_en         = 8'h00;
    reset          = 1'b1;
    expect_at(3, SIG_ST, 8'h00, "release_no_edge");
    expect_at(3, SIG_RD, 8'h00, "release_rd");
    tick(4);

    // All outputs, write 0xA5.
    gpio_direction = 8'h00;
    wr_en          = 1'b1;
    wr_data        = 8'hA5;
    expect_at(0, SIG_OE,  8'hFF, "wr_oe");
    expect_at(0, SIG_OUT, 8'h00, "wr_out_before");
    expect_at(1, SIG_OUT, 8'hA5, "wr_out");
    expect_at(1, SIG_RD,  8'h00, "wr_rd_lag");
    expect_at(2, SIG_RD,  8'hA5, "wr_rd");
    tick(1);
    wr_en = 1'b0;
    tick(2);

    // Switch to all inputs with pads at 0x3C.
    gpio_direction = 8'hFF;
    gpio_in        = 8'h3C;
    expect_at(0, SIG_OUT, 8'h00, "dirin_out");
    expect_at(0, SIG_OE,  8'h00, "dirin_oe");
    expect_at(2, SIG_RD,  8'h00, "dirin_rd_edge2");
    expect_at(2, SIG_ST,  8'h00, "dirin_st_edge2");
    expect_at(3, SIG_RD,  8'h3C, "dirin_rd_edge3");
    expect_at(3, SIG_ST,  irqv(8'h3C), "dirin_st_edge3");
    expect_at(3, SIG_IRQ, 8'h00, "dirin_irq_masked");
    tick(4);
    irq_clr = 8'hFF;
    expect_at(1, SIG_ST, 8'h00, "clr_all_1");
    tick(1);
    irq_clr = 8'h00;
    tick(1);

    // Mixed direction: low nibble input, high nibble output.
    gpio_direction = 8'h0F;
    wr_en          = 1'b1;
    wr_data        = 8'hFF;
    gpio_in        = 8'h05;
    expect_at(0, SIG_OE,  8'hF0, "mixed_oe");
    expect_at(0, SIG_OUT, 8'hA0, "mixed_out_old");
    expect_at(1, SIG_OUT, 8'hF0, "mixed_out");
    expect_at(2, SIG_RD,  8'hFC, "mixed_rd_edge2");
    expect_at(3, SIG_RD,  8'hF5, "mixed_rd");
    expect_at(3, SIG_ST,  irqv(8'h09), "mixed_st");
    tick(1);
    wr_en = 1'b0;
    tick(3);
    irq_clr = 8'hFF;
    expect_at(1, SIG_ST, 8'h00, "clr_all_2");
    tick(1);
    irq_clr = 8'h00;
    tick(1);

    // All inputs, settle pads low and clear resulting flags.
    gpio_direction = 8'hFF;
    gpio_in        = 8'h00;
    tick(4);
    irq_clr = 8'hFF;
    expect_at(1, SIG_ST, 8'h00, "clr_all_3");
    tick(1);
    irq_clr = 8'h00;
    tick(1);

    // Rising edge on pin 0 with pin 0 enabled.
    irq_en  = 8'h01;
    gpio_in = 8'h01;
    expect_at(2, SIG_ST,  8'h00, "p0_st_edge2");
    expect_at(2, SIG_IRQ, 8'h00, "p0_irq_edge2");
    expect_at(3, SIG_ST,  irqv(8'h01), "p0_st_edge3");
    expect_at(3, SIG_IRQ, irqv(8'h01), "p0_irq_edge3");
    tick(4);
    irq_en = 8'h00;
    expect_at(0, SIG_IRQ, 8'h00, "mask_irq");
    expect_at(0, SIG_ST,  irqv(8'h01), "mask_keeps_st");
    tick(1);
    irq_en  = 8'h01;
    irq_clr = 8'h01;
    expect_at(0, SIG_IRQ, irqv(8'h01), "unmask_irq");
    expect_at(1, SIG_ST,  8'h00, "clr_p0");
    expect_at(1, SIG_IRQ, 8'h00, "clr_p0_irq");
    tick(1);
    irq_clr = 8'h00;
    tick(1);

    // Falling edge on pin 0 whose flag lands on the same edge as a clear.
    gpio_in = 8'h00;
    tick(2);
    irq_clr = 8'h01;
    expect_at(1, SIG_ST,  irqv(8'h01), "set_wins_st");
    expect_at(1, SIG_IRQ, irqv(8'h01), "set_wins_irq");
    tick(1);
    irq_clr = 8'h00;
    expect_at(1, SIG_ST, irqv(8'h01), "set_wins_hold");
    tick(2);

    // Reset in mid-operation with out_reg=0xFF and a pending flag.
    gpio_direction = 8'h00;
    wr_en          = 1'b1;
    wr_data        = 8'hFF;
    tick(1);
    wr_en = 1'b0;
    expect_at(0, SIG_OUT, 8'hFF, "pre_rst_out");
    tick(1);
    reset = 1'b0;
    expect_at(0, SIG_OUT, 8'h00, "async_rst_out");
    expect_at(0, SIG_RD,  8'h00, "async_rst_rd");
    expect_at(0, SIG_ST,  8'h00, "async_rst_st");
    expect_at(0, SIG_IRQ, 8'h00, "async_rst_irq");
    tick(1);
    reset = 1'b1;
    expect_at(0, SIG_OUT, 8'h00, "post_rst_out0");
    expect_at(2, SIG_OUT, 8'h00, "post_rst_out2");
    expect_at(2, SIG_RD,  8'h00, "post_rst_rd");
    expect_at(2, SIG_ST,  8'h00, "post_rst_st");
    tick(3);
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    expect_at(1, SIG_OUT, 8'h5A, "post_rst_wr");
    tick(1);
    wr_en = 1'b0;
    tick(2);

    // Bounded drain: anything still queued was never compared.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    check("sb_drain", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
